// File: rtl/half_adder_pipe.sv
// Bank of WIDTH independent registered half adders with a valid qualifier and
// a saturating count of valid results that produced at least one carry.
module half_adder_pipe #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] c_out,
    output logic             any_carry,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic             carry_event;

    // NOTE: combinational block assigns every output unconditionally, so no latch is inferred.
    always_comb begin
        sum_d       = a ^ b;
        carry_d     = a & b;
        carry_event = in_valid & (|carry_d);
    end

    // Results are captured only under in_valid, so X on idle inputs never reaches the outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= '0;
            any_carry <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum       <= sum_d;
                c_out     <= carry_d;
                any_carry <= |carry_d;
            end
        end
    end

    // Clear has priority over a same-edge increment; the count sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (cnt_clr) begin
            carry_cnt <= '0;
        end else if (carry_event && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_half_adder_pipe.sv
// Directed bench for half_adder_pipe: truth table, hold, multi-lane, counter
// saturation/clear and asynchronous reset, across three parameterisations.
module tb_half_adder_pipe;

    logic clk;
    logic rst_n;

    // u1: WIDTH=1, CNT_W=16
    logic        v1, clr1, ov1, s1, c1, ac1;
    logic        a1, b1;
    logic [15:0] cnt1;
    // u4: WIDTH=4, CNT_W=16
    logic        v4, clr4, ov4, ac4;
    logic [3:0]  a4, b4, s4, c4;
    logic [15:0] cnt4;
    // u2: WIDTH=1, CNT_W=2
    logic        v2, clr2, ov2, s2, c2, ac2;
    logic        a2, b2;
    logic [1:0]  cnt2;

    int n_vec = 0;
    int n_err = 0;

    half_adder_pipe #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cnt_clr(clr1),
        .out_valid(ov1), .sum(s1), .c_out(c1), .any_carry(ac1), .carry_cnt(cnt1));

    half_adder_pipe #(.WIDTH(4), .CNT_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cnt_clr(clr4),
        .out_valid(ov4), .sum(s4), .c_out(c4), .any_carry(ac4), .carry_cnt(cnt4));

    half_adder_pipe #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .a(a2), .b(b2), .cnt_clr(clr2),
        .out_valid(ov2), .sum(s2), .c_out(c2), .any_carry(ac2), .carry_cnt(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] tt_ab   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] tt_cs   [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

    initial begin
        rst_n = 1'b0;
        {v1, a1, b1, clr1} = '0;
        {v4, a4, b4, clr4} = '0;
        {v2, a2, b2, clr2} = '0;
        #3;
        check("rst_ov",  32'(ov1),  32'd0);
        check("rst_sum", 32'(s4),   32'd0);
        check("rst_cnt", 32'(cnt1), 32'd0);
        tick();
        rst_n = 1'b1;

        // Truth table on lane 0, back to back
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1;
            {a1, b1} = tt_ab[i];
            tick();
            check($sformatf("tt%0d_sum", i), 32'(s1),  32'(tt_cs[i][0]));
            check($sformatf("tt%0d_co",  i), 32'(c1),  32'(tt_cs[i][1]));
            check($sformatf("tt%0d_ov",  i), 32'(ov1), 32'd1);
            check($sformatf("tt%0d_ac",  i), 32'(ac1), 32'(tt_cs[i][1]));
        end
        check("tt_cnt", 32'(cnt1), 32'd1);

        // Hold with X on idle inputs
        v1 = 1'b0;
        a1 = 1'bx;
        b1 = 1'bx;
        tick();
        check("hold_sum", 32'(s1),   32'd0);
        check("hold_co",  32'(c1),   32'd1);
        check("hold_ov",  32'(ov1),  32'd0);
        check("hold_ac",  32'(ac1),  32'd1);
        check("hold_cnt", 32'(cnt1), 32'd1);
        a1 = 1'b0;
        b1 = 1'b0;

        // Multi-lane, no inter-lane carry
        v4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
        tick();
        check("ml0_sum", 32'(s4),  32'h6);
        check("ml0_co",  32'(c4),  32'h8);
        check("ml0_ac",  32'(ac4), 32'd1);
        a4 = 4'b0101; b4 = 4'b1010;
        tick();
        check("ml1_sum", 32'(s4),   32'hf);
        check("ml1_co",  32'(c4),   32'h0);
        check("ml1_ac",  32'(ac4),  32'd0);
        check("ml1_ov",  32'(ov4),  32'd1);
        check("ml1_cnt", 32'(cnt4), 32'd1);
        v4 = 1'b0;
        tick();
        check("ml_idle_ov", 32'(ov4), 32'd0);

        // Counter saturation at 3, then clear beats increment
        v2 = 1'b1; a2 = 1'b1; b2 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sat%0d_cnt", i), 32'(cnt2), (i < 3) ? 32'(i) : 32'd3);
        end
        clr2 = 1'b1;
        tick();
        check("clr_cnt", 32'(cnt2), 32'd0);
        check("clr_co",  32'(c2),   32'd1);
        check("clr_ov",  32'(ov2),  32'd1);
        clr2 = 1'b0;
        v2 = 1'b0;
        tick();
        check("post_clr_cnt", 32'(cnt2), 32'd0);

        // Asynchronous reset mid-cycle with an in-flight result
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        check("pre_rst_co",  32'(c1),   32'd1);
        check("pre_rst_cnt", 32'(cnt1), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ov",  32'(ov1),  32'd0);
        check("arst_sum", 32'(s1),   32'd0);
        check("arst_co",  32'(c1),   32'd0);
        check("arst_ac",  32'(ac1),  32'd0);
        check("arst_cnt", 32'(cnt1), 32'd0);
        v1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_ov",  32'(ov1),  32'd0);
        check("rel_cnt", 32'(cnt1), 32'd0);
        check("rel_co",  32'(c1),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
